// File: rtl/avalon_mem_pkg.sv
// avalon_mem_pkg
// Shared declarations for the Avalon-MM memory target slice.
//   state_t      : transfer FSM states (IDLE, WAIT, ACK)
//   rd_src_t     : what the registered read-data output currently shows
//   RD_ERR_DATA  : data returned for reads outside the memory window
//   WAIT_CNT_W   : width of the stall counter (covers WAIT_CYCLES 0..15)
package avalon_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

  // The read-data register stores a source selector instead of a 32-bit
  // copy. The RAM holds its own registered output, so only the selector
  // needs a reset value.
  typedef enum logic [1:0] {
    RD_SRC_ZERO = 2'd0,
    RD_SRC_RAM  = 2'd1,
    RD_SRC_ERR  = 2'd2
  } rd_src_t;

  localparam logic [31:0] RD_ERR_DATA = 32'hDEAD_BEEF;
  localparam int          WAIT_CNT_W  = 4;

endpackage

// File: rtl/avalon_mem_ram.sv
// avalon_mem_ram
// Single-port DEPTH_WORDS x 32 storage with a synchronous write and a
// registered read. Contents have no reset.
// Ports:
//   clk    : clock, rising edge
//   en     : port enable; nothing happens when low
//   we     : 1 = write wdata to addr, 0 = read addr into rdata
//   addr   : word index
//   wdata  : write data
//   rdata  : registered read data; it holds its value until the next read
module avalon_mem_ram #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned ADDR_W      = 8
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // One access per cycle. A write leaves rdata unchanged, so the last
  // read result stays visible.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/avalon_mem_target.sv
// avalon_mem_target
// Avalon-MM slave that maps a DEPTH_WORDS x 32 memory at BASE_ADDR.
// Each transfer stalls for WAIT_CYCLES cycles. The target also keeps
// completed-transfer counters and a sticky error flag.
// Ports:
//   clk, reset        : clock (rising edge) and async active-high reset
//   avs_read/write    : requests, held by the initiator while waitrequest is high
//   avs_address       : byte address, bits [1:0] ignored
//   avs_writedata     : write data
//   avs_readdata      : registered read data, valid in the read's ACK cycle
//   avs_waitrequest   : low only in the completing (ACK) cycle
//   err_clr / err     : synchronous clear / sticky error (out of window or rd&wr)
//   rd_count/wr_count : completed reads / writes, wrapping
module avalon_mem_target
  import avalon_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [31:0] avs_address,
  input  logic [31:0] avs_writedata,
  output logic [31:0] avs_readdata,
  output logic        avs_waitrequest,
  input  logic        err_clr,
  output logic        err,
  output logic [31:0] rd_count,
  output logic [31:0] wr_count
);

  localparam int unsigned ADDR_W = $clog2(DEPTH_WORDS);

  // The window size is 33 bits wide because BASE_ADDR + window can reach 2^32.
  localparam logic [32:0] WINDOW_BYTES = 33'(DEPTH_WORDS) << 2;

  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
    (WAIT_CYCLES > 0) ? WAIT_CNT_W'(WAIT_CYCLES - 1) : '0;

  state_t                  state_q, state_d;
  logic [WAIT_CNT_W-1:0]   cnt_q, cnt_d;
  logic                    load_req;

  logic [31:0]             addr_q;
  logic [31:0]             wdata_q;
  logic                    is_write_q;
  logic                    both_q;

  rd_src_t                 rd_src_q;
  logic                    err_q;
  logic [31:0]             rd_count_q;
  logic [31:0]             wr_count_q;

  logic [31:0]             cur_addr;
  logic [32:0]             addr_diff;
  logic                    in_window;
  logic                    next_write;
  logic                    enter_ack;
  logic                    complete;
  logic                    ram_rd;
  logic                    ram_wr;
  logic [31:0]             ram_rdata;

  // In IDLE the request is being latched in this cycle, so the live bus
  // address is used. With WAIT_CYCLES = 0 the read must also be launched
  // from it. In every other state the latched address is used.
  assign cur_addr   = (state_q == IDLE) ? avs_address : addr_q;
  assign next_write = (state_q == IDLE) ? avs_write   : is_write_q;

  // Bit 32 of the difference is the borrow, which means the address is below the base.
  assign addr_diff  = {1'b0, cur_addr} - {1'b0, BASE_ADDR};
  assign in_window  = !addr_diff[32] && (addr_diff < WINDOW_BYTES);

  assign enter_ack  = (state_d == ACK);
  assign complete   = (state_q == ACK);

  // The read is launched on the edge into ACK, so the data is registered
  // during the ACK cycle. The write happens on the edge that ends ACK.
  // These never share a cycle, so one RAM port is enough.
  assign ram_rd     = enter_ack && !next_write && in_window;
  assign ram_wr     = complete && is_write_q && in_window;

  avalon_mem_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .ADDR_W      (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .en    (ram_rd || ram_wr),
    .we    (ram_wr),
    .addr  (cur_addr[ADDR_W+1:2]),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  // State register for the transfer FSM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. The stall counter is loaded when a request is
  // accepted. It counts down in WAIT. If the request disappears in WAIT,
  // the transfer is dropped without side effects.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    load_req = 1'b0;
    case (state_q)
      IDLE: begin
        if (avs_read || avs_write) begin
          load_req = 1'b1;
          state_d  = (WAIT_CYCLES > 0) ? WAIT : ACK;
        end
      end
      WAIT: begin
        if (!(avs_read || avs_write)) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          state_d = ACK;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Request capture and the wait counter. A request with both read and
  // write high is stored as a write, and both_q remembers it for the error flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      is_write_q <= 1'b0;
      both_q     <= 1'b0;
      cnt_q      <= '0;
    end else if (load_req) begin
      addr_q     <= avs_address;
      wdata_q    <= avs_writedata;
      is_write_q <= avs_write;
      both_q     <= avs_read && avs_write;
      cnt_q      <= WAIT_LOAD;
    end else begin
      cnt_q      <= cnt_d;
    end
  end

  // Read-data source, completion counters and the sticky error flag.
  // A new error takes priority over err_clr in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_src_q   <= RD_SRC_ZERO;
      rd_count_q <= '0;
      wr_count_q <= '0;
      err_q      <= 1'b0;
    end else begin
      if (enter_ack && !next_write) begin
        rd_src_q <= in_window ? RD_SRC_RAM : RD_SRC_ERR;
      end
      if (complete) begin
        if (is_write_q) begin
          wr_count_q <= wr_count_q + 32'd1;
        end else begin
          rd_count_q <= rd_count_q + 32'd1;
        end
      end
      if (complete && (!in_window || both_q)) begin
        err_q <= 1'b1;
      end else if (err_clr) begin
        err_q <= 1'b0;
      end
    end
  end

  // Read-data output mux driven by the registered source selector.
  always_comb begin
    avs_readdata = '0;
    case (rd_src_q)
      RD_SRC_RAM:  avs_readdata = ram_rdata;
      RD_SRC_ERR:  avs_readdata = RD_ERR_DATA;
      default:     avs_readdata = '0;
    endcase
  end

  assign avs_waitrequest = (state_q != ACK);
  assign err             = err_q;
  assign rd_count        = rd_count_q;
  assign wr_count        = wr_count_q;

endmodule

// File: tb/tb_avalon_mem_target.sv
// tb_avalon_mem_target
// Two instances share clk and reset:
//   dut_a : 16 words at base 0 with 2 wait cycles
//   dut_b : 16 words at base 0 with 0 wait cycles
// Inputs are driven 1 time unit after the rising edge. Outputs are
// sampled on the falling edge.
module tb_avalon_mem_target;

  localparam int          DEPTH = 16;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int          A_LAT = 3;
  localparam int          B_LAT = 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic        a_read = 0, a_write = 0, a_err_clr = 0;
  logic [31:0] a_address = 0, a_writedata = 0;
  logic [31:0] a_readdata, a_rd_count, a_wr_count;
  logic        a_waitrequest, a_err;

  logic        b_read = 0, b_write = 0, b_err_clr = 0;
  logic [31:0] b_address = 0, b_writedata = 0;
  logic [31:0] b_readdata, b_rd_count, b_wr_count;
  logic        b_waitrequest, b_err;

  int checks = 0;
  int errors = 0;

  // Reference model for dut_a: word array, counters, error flag, last read data.
  logic [31:0] mem_a [DEPTH];
  logic [31:0] m_rd, m_wr, m_last;
  logic        m_err;

  always #5 clk = ~clk;

  avalon_mem_target #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(2)) dut_a (
    .clk(clk), .reset(reset), .avs_read(a_read), .avs_write(a_write),
    .avs_address(a_address), .avs_writedata(a_writedata), .avs_readdata(a_readdata),
    .avs_waitrequest(a_waitrequest), .err_clr(a_err_clr), .err(a_err),
    .rd_count(a_rd_count), .wr_count(a_wr_count));

  avalon_mem_target #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(0)) dut_b (
    .clk(clk), .reset(reset), .avs_read(b_read), .avs_write(b_write),
    .avs_address(b_address), .avs_writedata(b_writedata), .avs_readdata(b_readdata),
    .avs_waitrequest(b_waitrequest), .err_clr(b_err_clr), .err(b_err),
    .rd_count(b_rd_count), .wr_count(b_wr_count));

  function automatic bit in_win(input logic [31:0] addr);
    longint a = longint'(addr);
    return (a >= longint'(BASE)) && (a < longint'(BASE) + 4 * DEPTH);
  endfunction

  // Applies one completed transfer to the model and returns the expected readdata.
  task automatic model_a(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] data, output logic [31:0] exp);
    bit ok = in_win(addr);
    int idx = int'((longint'(addr) - longint'(BASE)) / 4);
    if (wr) begin
      exp = m_last;
      if (ok) mem_a[idx] = data;
      m_wr = m_wr + 1;
    end else begin
      exp = ok ? mem_a[idx] : 32'hDEAD_BEEF;
      m_last = exp;
      m_rd = m_rd + 1;
    end
    if (!ok || (rd && wr)) m_err = 1'b1;
  endtask

  task automatic model_reset();
    m_rd = 0; m_wr = 0; m_last = 0; m_err = 0;
  endtask

  // Drives one transfer on dut_a. It is entered at edge+1 and returns at
  // edge+1 after ACK. lat is the number of sampled waitrequest-high cycles.
  task automatic a_xfer(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, output int lat, output logic [31:0] rdata);
    a_read = rd; a_write = wr; a_address = addr; a_writedata = data;
    lat = 0; rdata = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!a_waitrequest) begin
        rdata = a_readdata;
        break;
      end
      lat++;
    end
    @(posedge clk); #1;
    a_read = 0; a_write = 0;
  endtask

  task automatic b_xfer(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, output int lat, output logic [31:0] rdata);
    b_read = rd; b_write = wr; b_address = addr; b_writedata = data;
    lat = 0; rdata = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!b_waitrequest) begin
        rdata = b_readdata;
        break;
      end
      lat++;
    end
    @(posedge clk); #1;
    b_read = 0; b_write = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #3;
    checks++; if (a_waitrequest !== 1'b1) begin errors++; $display("[TB] FAIL rst_a_wait got %b expected 1", a_waitrequest); end
    checks++; if (a_readdata !== 32'h0) begin errors++; $display("[TB] FAIL rst_a_rdata got %h expected 00000000", a_readdata); end
    checks++; if (a_err !== 1'b0) begin errors++; $display("[TB] FAIL rst_a_err got %b expected 0", a_err); end
    checks++; if (a_rd_count !== 32'd0) begin errors++; $display("[TB] FAIL rst_a_rdcnt got %0d expected 0", a_rd_count); end
    checks++; if (a_wr_count !== 32'd0) begin errors++; $display("[TB] FAIL rst_a_wrcnt got %0d expected 0", a_wr_count); end
    checks++; if (b_waitrequest !== 1'b1) begin errors++; $display("[TB] FAIL rst_b_wait got %b expected 1", b_waitrequest); end
    checks++; if (b_readdata !== 32'h0) begin errors++; $display("[TB] FAIL rst_b_rdata got %h expected 00000000", b_readdata); end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    int lat; logic [31:0] rd, exp;
    a_xfer(0, 1, 32'h8, 32'hCAFE_0001, lat, rd);
    model_a(0, 1, 32'h8, 32'hCAFE_0001, exp);
    checks++; if (lat !== A_LAT) begin errors++; $display("[TB] FAIL wr_latency got %0d expected %0d", lat, A_LAT); end
    a_xfer(1, 0, 32'h8, 32'h0, lat, rd);
    model_a(1, 0, 32'h8, 32'h0, exp);
    checks++; if (lat !== A_LAT) begin errors++; $display("[TB] FAIL rd_latency got %0d expected %0d", lat, A_LAT); end
    checks++; if (rd !== 32'hCAFE_0001) begin errors++; $display("[TB] FAIL rd_data got %h expected cafe0001", rd); end
    checks++; if (a_wr_count !== 32'd1) begin errors++; $display("[TB] FAIL wr_count1 got %0d expected 1", a_wr_count); end
    checks++; if (a_rd_count !== 32'd1) begin errors++; $display("[TB] FAIL rd_count1 got %0d expected 1", a_rd_count); end
    checks++; if (a_err !== 1'b0) begin errors++; $display("[TB] FAIL err_after_rw got %b expected 0", a_err); end
  endtask

  task automatic test_random();
    int lat; logic [31:0] rd, exp, addr, data;
    logic r, w;
    for (int i = 0; i < DEPTH; i++) begin
      data = $urandom;
      a_xfer(0, 1, BASE + 32'(i * 4), data, lat, rd);
      model_a(0, 1, BASE + 32'(i * 4), data, exp);
    end
    for (int n = 0; n < 48; n++) begin
      addr = BASE + 32'($urandom_range(0, DEPTH + 3) * 4) + 32'($urandom_range(0, 3));
      data = $urandom;
      case ($urandom_range(0, 7))
        0:       begin r = 1; w = 1; end
        1, 2, 3: begin r = 0; w = 1; end
        default: begin r = 1; w = 0; end
      endcase
      a_xfer(r, w, addr, data, lat, rd);
      model_a(r, w, addr, data, exp);
      checks++; if (lat !== A_LAT) begin errors++; $display("[TB] FAIL rnd_lat n=%0d got %0d expected %0d", n, lat, A_LAT); end
      checks++; if (rd !== exp) begin errors++; $display("[TB] FAIL rnd_rdata n=%0d addr=%h got %h expected %h", n, addr, rd, exp); end
      checks++; if (a_rd_count !== m_rd) begin errors++; $display("[TB] FAIL rnd_rdcnt n=%0d got %0d expected %0d", n, a_rd_count, m_rd); end
      checks++; if (a_wr_count !== m_wr) begin errors++; $display("[TB] FAIL rnd_wrcnt n=%0d got %0d expected %0d", n, a_wr_count, m_wr); end
      checks++; if (a_err !== m_err) begin errors++; $display("[TB] FAIL rnd_err n=%0d got %b expected %b", n, a_err, m_err); end
    end
  endtask

  task automatic test_err();
    int lat; logic [31:0] rd, exp, data;
    a_err_clr = 1; @(posedge clk); #1 a_err_clr = 0; m_err = 0;
    checks++; if (a_err !== 1'b0) begin errors++; $display("[TB] FAIL err_clear0 got %b expected 0", a_err); end
    a_xfer(1, 0, BASE + 32'(4 * DEPTH), 0, lat, rd);
    model_a(1, 0, BASE + 32'(4 * DEPTH), 0, exp);
    checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL oob_rdata got %h expected deadbeef", rd); end
    checks++; if (a_err !== 1'b1) begin errors++; $display("[TB] FAIL oob_err got %b expected 1", a_err); end
    a_err_clr = 1; @(posedge clk); #1 a_err_clr = 0; m_err = 0;
    checks++; if (a_err !== 1'b0) begin errors++; $display("[TB] FAIL err_clr_pulse got %b expected 0", a_err); end
    // err_clr held through an out-of-window write: the new error must win.
    a_err_clr = 1;
    a_xfer(0, 1, BASE + 32'(4 * DEPTH + 12), 32'h5555_AAAA, lat, rd);
    model_a(0, 1, BASE + 32'(4 * DEPTH + 12), 32'h5555_AAAA, exp);
    a_err_clr = 0;
    checks++; if (a_err !== 1'b1) begin errors++; $display("[TB] FAIL err_set_wins got %b expected 1", a_err); end
    checks++; if (a_wr_count !== m_wr) begin errors++; $display("[TB] FAIL oob_wrcnt got %0d expected %0d", a_wr_count, m_wr); end
    a_err_clr = 1; @(posedge clk); #1 a_err_clr = 0; m_err = 0;
    // read and write together behave as a write and flag an error
    data = $urandom;
    a_xfer(1, 1, BASE + 32'h4, data, lat, rd);
    model_a(1, 1, BASE + 32'h4, data, exp);
    checks++; if (a_err !== 1'b1) begin errors++; $display("[TB] FAIL both_err got %b expected 1", a_err); end
    a_xfer(1, 0, BASE + 32'h4, 0, lat, rd);
    model_a(1, 0, BASE + 32'h4, 0, exp);
    checks++; if (rd !== data) begin errors++; $display("[TB] FAIL both_as_write got %h expected %h", rd, data); end
    a_err_clr = 1; @(posedge clk); #1 a_err_clr = 0; m_err = 0;
  endtask

  task automatic test_abort();
    int lat, lows; logic [31:0] rd, exp;
    a_read = 1; a_address = BASE + 32'hC;
    @(posedge clk); #1;
    a_read = 0;
    lows = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (!a_waitrequest) lows++;
    end
    @(posedge clk); #1;
    checks++; if (lows !== 0) begin errors++; $display("[TB] FAIL abort_wait_low got %0d expected 0", lows); end
    checks++; if (a_rd_count !== m_rd) begin errors++; $display("[TB] FAIL abort_rdcnt got %0d expected %0d", a_rd_count, m_rd); end
    checks++; if (a_err !== 1'b0) begin errors++; $display("[TB] FAIL abort_err got %b expected 0", a_err); end
    a_xfer(1, 0, BASE + 32'hC, 0, lat, rd);
    model_a(1, 0, BASE + 32'hC, 0, exp);
    checks++; if (lat !== A_LAT) begin errors++; $display("[TB] FAIL after_abort_lat got %0d expected %0d", lat, A_LAT); end
    checks++; if (rd !== exp) begin errors++; $display("[TB] FAIL after_abort_rdata got %h expected %h", rd, exp); end
  endtask

  task automatic test_latched();
    int lat; logic [31:0] rd, exp, d1;
    bit done = 0;
    d1 = $urandom;
    a_write = 1; a_address = BASE + 32'h14; a_writedata = d1;
    @(posedge clk); #1;
    a_address = BASE + 32'h18; a_writedata = ~d1;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (!a_waitrequest) done = 1;
    end
    @(posedge clk); #1 a_write = 0;
    checks++; if (!done) begin errors++; $display("[TB] FAIL latched_timeout got 0 expected 1"); end
    model_a(0, 1, BASE + 32'h14, d1, exp);
    a_xfer(1, 0, BASE + 32'h14, 0, lat, rd);
    model_a(1, 0, BASE + 32'h14, 0, exp);
    checks++; if (rd !== exp) begin errors++; $display("[TB] FAIL latched_addr got %h expected %h", rd, exp); end
    a_xfer(1, 0, BASE + 32'h18, 0, lat, rd);
    model_a(1, 0, BASE + 32'h18, 0, exp);
    checks++; if (rd !== exp) begin errors++; $display("[TB] FAIL latched_other got %h expected %h", rd, exp); end
  endtask

  task automatic test_reset_mid();
    int lat; logic [31:0] rd, exp;
    a_write = 1; a_address = BASE + 32'h10; a_writedata = 32'h1234_5678;
    @(posedge clk); #1;
    #2 reset = 1'b1;
    #1;
    checks++; if (a_waitrequest !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_wait got %b expected 1", a_waitrequest); end
    checks++; if (a_rd_count !== 32'd0) begin errors++; $display("[TB] FAIL rstmid_rdcnt got %0d expected 0", a_rd_count); end
    checks++; if (a_wr_count !== 32'd0) begin errors++; $display("[TB] FAIL rstmid_wrcnt got %0d expected 0", a_wr_count); end
    checks++; if (a_err !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_err got %b expected 0", a_err); end
    a_write = 0;
    @(posedge clk); #1 reset = 1'b0;
    model_reset();
    @(posedge clk); #1;
    a_xfer(1, 0, BASE + 32'h10, 0, lat, rd);
    model_a(1, 0, BASE + 32'h10, 0, exp);
    checks++; if (rd !== exp) begin errors++; $display("[TB] FAIL rstmid_prior got %h expected %h", rd, exp); end
  endtask

  task automatic test_back_to_back();
    int lat; logic [31:0] rd;
    logic [31:0] words [4];
    time t0;
    for (int i = 0; i < 4; i++) begin
      words[i] = $urandom;
      b_xfer(0, 1, BASE + 32'(i * 4), words[i], lat, rd);
    end
    t0 = $time;
    for (int i = 0; i < 4; i++) begin
      b_xfer(1, 0, BASE + 32'(i * 4), 0, lat, rd);
      checks++; if (lat !== B_LAT) begin errors++; $display("[TB] FAIL b2b_lat i=%0d got %0d expected %0d", i, lat, B_LAT); end
      checks++; if (rd !== words[i]) begin errors++; $display("[TB] FAIL b2b_rdata i=%0d got %h expected %h", i, rd, words[i]); end
    end
    checks++; if ($time - t0 !== 80) begin errors++; $display("[TB] FAIL b2b_time got %0t expected 80", $time - t0); end
    checks++; if (b_rd_count !== 32'd4) begin errors++; $display("[TB] FAIL b2b_rdcnt got %0d expected 4", b_rd_count); end
    checks++; if (b_wr_count !== 32'd4) begin errors++; $display("[TB] FAIL b2b_wrcnt got %0d expected 4", b_wr_count); end
  endtask

  task automatic test_dma();
    int lat; logic [31:0] rd, exp;
    logic [31:0] moved [6];
    reset = 1'b1; @(posedge clk); #1 reset = 1'b0;
    model_reset();
    for (int blk = 0; blk < 3; blk++) begin
      for (int k = 0; k < 2; k++) begin
        a_xfer(1, 0, BASE + 32'((blk * 2 + k) * 4), 0, lat, rd);
        model_a(1, 0, BASE + 32'((blk * 2 + k) * 4), 0, exp);
        moved[blk * 2 + k] = rd;
        checks++; if (rd !== exp) begin errors++; $display("[TB] FAIL dma_src idx=%0d got %h expected %h", blk * 2 + k, rd, exp); end
      end
      for (int k = 0; k < 2; k++) begin
        a_xfer(0, 1, BASE + 32'h20 + 32'((blk * 2 + k) * 4), moved[blk * 2 + k], lat, rd);
        model_a(0, 1, BASE + 32'h20 + 32'((blk * 2 + k) * 4), moved[blk * 2 + k], exp);
      end
    end
    checks++; if (a_wr_count !== 32'd6) begin errors++; $display("[TB] FAIL dma_wrcnt got %0d expected 6", a_wr_count); end
    checks++; if (a_rd_count !== 32'd6) begin errors++; $display("[TB] FAIL dma_rdcnt got %0d expected 6", a_rd_count); end
    checks++; if (a_err !== 1'b0) begin errors++; $display("[TB] FAIL dma_err got %b expected 0", a_err); end
    for (int i = 0; i < 6; i++) begin
      a_xfer(1, 0, BASE + 32'h20 + 32'(i * 4), 0, lat, rd);
      model_a(1, 0, BASE + 32'h20 + 32'(i * 4), 0, exp);
      checks++; if (rd !== exp) begin errors++; $display("[TB] FAIL dma_dst idx=%0d got %h expected %h", i, rd, exp); end
    end
  endtask

  initial begin
    $display("[TB] starting avalon_mem_target bench");
    test_reset();
    test_write_read();
    test_random();
    test_err();
    test_abort();
    test_latched();
    test_reset_mid();
    test_back_to_back();
    test_dma();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/avalon_mem_target.md
AVALON_MEM_TARGET -- requirements
Module: avalon_mem_target

Interface
REQ-001 Parameter DEPTH_WORDS, default 256, number of 32-bit words stored; power of two, range 4..65536.
REQ-002 Parameter BASE_ADDR, default 32'h0000_0000, byte base address of the window; aligned to DEPTH_WORDS*4.
REQ-003 Parameter WAIT_CYCLES, default 2, extra stall cycles per transfer; range 0..15.
REQ-004 clk  in  1  single clock; all logic on the rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 avs_read  in  1  read request, held by the initiator until waitrequest is low.
REQ-007 avs_write  in  1  write request, held by the initiator until waitrequest is low.
REQ-008 avs_address  in  32  byte address; bits [1:0] are ignored.
REQ-009 avs_writedata  in  32  write data.
REQ-010 avs_readdata  out  32  read data; valid in the cycle avs_waitrequest is low for a read.
REQ-011 avs_waitrequest  out  1  stall; low only in the completing cycle of a transfer.
REQ-012 err_clr  in  1  synchronous clear of err.
REQ-013 err  out  1  sticky error flag: out-of-window access or simultaneous read and write.
REQ-014 rd_count  out  32  number of completed reads, wraps modulo 2^32.
REQ-015 wr_count  out  32  number of completed writes, wraps modulo 2^32.

Function
REQ-016 FSM states: IDLE, WAIT, ACK; avs_waitrequest = 0 only in ACK, 1 in IDLE and WAIT.
REQ-017 IDLE with (avs_read|avs_write) = 1 latches address, writedata and direction, and loads wait counter = WAIT_CYCLES-1; next state is WAIT if WAIT_CYCLES > 0, otherwise ACK.
REQ-018 WAIT decrements the counter each cycle and moves to ACK when the counter is 0 and the request is still asserted.
REQ-019 WAIT with avs_read = avs_write = 0 aborts to IDLE; no memory update, no counter update, no err.
REQ-020 A request first seen in IDLE at cycle 0 completes, with avs_waitrequest low, in cycle WAIT_CYCLES+1.
REQ-021 ACK always returns to IDLE on the next cycle; a request held there starts a new transfer, so back-to-back transfers cost WAIT_CYCLES+2 cycles each.
REQ-022 Read: word index = (latched address - BASE_ADDR) >> 2; avs_readdata is registered on entry to ACK and held until the next read completes.
REQ-023 Write: memory word is updated at the clock edge that ends the ACK cycle.
REQ-024 Out-of-window access, where address < BASE_ADDR or address >= BASE_ADDR + 4*DEPTH_WORDS:
- read returns 32'hDEAD_BEEF;
- write is dropped;
- err is set; the transfer still completes normally and is counted.
REQ-025 avs_read and avs_write both high when latched: treated as a write and err is set.
REQ-026 Address or data changes in WAIT are ignored; the latched values are used.
REQ-027 rd_count and wr_count increment by 1 at the end of each ACK cycle of the matching direction.
REQ-028 err_clr clears err; if err_clr and a new error occur in the same cycle, err is set (set wins).

Reset
REQ-029 On reset assertion the FSM goes to IDLE immediately, avs_waitrequest = 1, avs_readdata = 0, err = 0, rd_count = 0, wr_count = 0.
REQ-030 Memory contents are not reset.
REQ-031 Reset during WAIT or ACK abandons the transfer without a memory write and without a count update.

Structure
REQ-032 Package avalon_mem_pkg holds the state enum, the constant RD_ERR_DATA = 32'hDEAD_BEEF, and the wait counter width (4).
REQ-033 Storage is in one sub-module, avalon_mem_ram: single-port, synchronous write, with a registered-read-compatible array of DEPTH_WORDS x 32.

Verification
REQ-034 WAIT_CYCLES=2: write 32'hCAFE_0001 to addr 0x8, then read addr 0x8 -> waitrequest high for 3 cycles, low in cycle 3; readdata = 32'hCAFE_0001; wr_count = 1, rd_count = 1.
REQ-035 WAIT_CYCLES=0: four back-to-back reads of addrs 0x0..0xC, each address held until waitrequest is low -> each read completes in cycle 1 of its request; rd_count = 4.
REQ-036 Read of BASE_ADDR + 4*DEPTH_WORDS -> readdata = 32'hDEAD_BEEF, err = 1; pulse err_clr -> err = 0 on the next cycle.
REQ-037 Assert avs_read, then drop it during WAIT -> FSM returns to IDLE; rd_count unchanged; next read completes normally.
REQ-038 Assert reset during WAIT of a write of 32'h1234_5678 to 0x10 -> after reset, a read of 0x10 returns the prior contents; all counters = 0.
REQ-039 Drive the DMA sequence (2 reads, then 2 writes, repeated for 3 blocks) with the initiator stalling on waitrequest -> all 6 destination words are written, wr_count = 6, rd_count = 6, err = 0.
